mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter, its two requesters (fetch, data) and the shared memory.
// slave = arbiter side, master = requester/memory side.
`timescale 1ns/1ps
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_digit;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_digit;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_digit, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_digit, busy, owner
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_digit, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_digit, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data) in front of one fixed-latency memory.
// Data has priority; fetch is forced through after STREAK_MAX consecutive data grants.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STREAK_MAX = 2
) (
    input  logic          CLK,
    input  logic          Reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LP_CNT_INIT = 3'(MEM_LAT - 1);
    localparam logic [1:0] LP_SMAX     = 2'(STREAK_MAX);

    state_t      r_state, w_next;
    logic [2:0]  r_cnt;
    logic [1:0]  r_streak;
    logic        r_owner;
    logic [31:0] r_addr, r_wdata, r_if_rdata, r_dm_rdata;
    logic        r_we;
    logic [1:0]  r_digit;
    logic        w_start, w_grant_dm;

    assign w_start    = (r_state == IDLE) && (bus.if_req || bus.dm_req);
    assign w_grant_dm = bus.dm_req && !(bus.if_req && (r_streak == LP_SMAX));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.if_req || bus.dm_req) w_next = ACCESS;
            ACCESS:  if (r_cnt == 3'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cnt      <= '0;
            r_streak   <= '0;
            r_owner    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_digit    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_start) begin
            r_owner <= w_grant_dm;
            r_cnt   <= LP_CNT_INIT;
            if (w_grant_dm) begin
                r_addr   <= bus.dm_addr;
                r_wdata  <= bus.dm_wdata;
                r_we     <= bus.dm_we;
                r_digit  <= bus.dm_digit;
                // streak only counts data grants that actually made fetch wait
                if (!bus.if_req)           r_streak <= '0;
                else if (r_streak != 2'd3) r_streak <= r_streak + 2'd1;
            end else begin
                r_addr   <= bus.if_addr;
                r_wdata  <= '0;
                r_we     <= 1'b0;
                r_digit  <= 2'b10;
                r_streak <= '0;
            end
        end else if (r_state == ACCESS) begin
            if (r_cnt == 3'd0) begin
                if (!r_owner)   r_if_rdata <= bus.mem_rdata;
                else if (!r_we) r_dm_rdata <= bus.mem_rdata;
            end else begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign bus.mem_en    = (r_state == ACCESS);
    assign bus.mem_we    = (r_state == ACCESS) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_digit = r_digit;
    assign bus.if_ack    = (r_state == RESP) && !r_owner;
    assign bus.dm_ack    = (r_state == RESP) && r_owner;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.busy      = (r_state != IDLE);
    assign bus.owner     = r_owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    mem_arbiter_if ifc();
    mem_arbiter #(.MEM_LAT(LAT), .STREAK_MAX(SMAX)) dut (
        .CLK(CLK), .Reset(Reset), .bus(ifc.slave)
    );

    logic [31:0] mem_word;
    assign ifc.mem_rdata = mem_word;

    int errs = 0, checks = 0;
    // transaction-level model state
    int          m_streak;
    logic        m_owner;
    logic [31:0] m_if_rd, m_dm_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_streak = 0; m_owner = 1'b0; m_if_rd = '0; m_dm_rd = '0;
    endtask

    // Called in an IDLE cycle with requests already driven; walks ACCESS, RESP and the next IDLE.
    task automatic run_txn(input bit hold, input bit drop, input bit garble);
        logic        dm_win, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_dig;
        dm_win = ifc.dm_req && !(ifc.if_req && m_streak == SMAX);
        if (dm_win) begin
            e_addr = ifc.dm_addr; e_wdata = ifc.dm_wdata; e_we = ifc.dm_we; e_dig = ifc.dm_digit;
            m_streak = ifc.if_req ? ((m_streak < 3) ? m_streak + 1 : 3) : 0;
        end else begin
            e_addr = ifc.if_addr; e_wdata = '0; e_we = 1'b0; e_dig = 2'b10;
            m_streak = 0;
        end
        m_owner = dm_win;
        tick();
        for (int k = 1; k <= LAT; k++) begin
            chk("acc_en",    32'(ifc.mem_en), 32'd1);
            chk("acc_busy",  32'(ifc.busy), 32'd1);
            chk("acc_addr",  ifc.mem_addr, e_addr);
            chk("acc_we",    32'(ifc.mem_we), 32'(e_we));
            chk("acc_digit", 32'(ifc.mem_digit), 32'(e_dig));
            if (dm_win) chk("acc_wdata", ifc.mem_wdata, e_wdata);
            chk("acc_owner", 32'(ifc.owner), 32'(m_owner));
            chk("acc_noack", 32'({ifc.if_ack, ifc.dm_ack}), 32'd0);
            if (k == 1 && drop) begin
                if (dm_win) ifc.dm_req = 1'b0; else ifc.if_req = 1'b0;
            end
            if (garble) begin
                ifc.if_addr = $urandom; ifc.dm_addr = $urandom; ifc.dm_wdata = $urandom;
                ifc.dm_we = 1'($urandom); ifc.dm_digit = 2'($urandom_range(0, 2));
            end
            tick();
        end
        if (!dm_win)    m_if_rd = mem_word;
        else if (!e_we) m_dm_rd = mem_word;
        chk("resp_if_ack", 32'(ifc.if_ack), 32'(!dm_win));
        chk("resp_dm_ack", 32'(ifc.dm_ack), 32'(dm_win));
        chk("resp_en",     32'({ifc.mem_en, ifc.mem_we}), 32'd0);
        chk("resp_busy",   32'(ifc.busy), 32'd1);
        chk("resp_if_rd",  ifc.if_rdata, m_if_rd);
        chk("resp_dm_rd",  ifc.dm_rdata, m_dm_rd);
        if (!hold) begin
            if (dm_win) ifc.dm_req = 1'b0; else ifc.if_req = 1'b0;
        end
        tick();
        chk("idle_busy",  32'(ifc.busy), 32'd0);
        chk("idle_quiet", 32'({ifc.mem_en, ifc.mem_we, ifc.if_ack, ifc.dm_ack}), 32'd0);
        chk("idle_owner", 32'(ifc.owner), 32'(m_owner));
        chk("idle_if_rd", ifc.if_rdata, m_if_rd);
        chk("idle_dm_rd", ifc.dm_rdata, m_dm_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  order;
        logic [31:0] saved;
        logic [1:0]  r;
        Reset = 1'b0;
        ifc.if_req = 0; ifc.if_addr = '0; ifc.dm_req = 0; ifc.dm_we = 0;
        ifc.dm_addr = '0; ifc.dm_wdata = '0; ifc.dm_digit = '0;
        mem_word = '0;
        model_reset();
        #12;
        chk("rst_busy",  32'(ifc.busy), 32'd0);
        chk("rst_owner", 32'(ifc.owner), 32'd0);
        chk("rst_quiet", 32'({ifc.mem_en, ifc.mem_we, ifc.if_ack, ifc.dm_ack}), 32'd0);
        chk("rst_addr",  ifc.mem_addr, 32'd0);
        chk("rst_if_rd", ifc.if_rdata, 32'd0);
        chk("rst_dm_rd", ifc.dm_rdata, 32'd0);
        @(negedge CLK); Reset = 1'b1;
        tick();

        // fetch only
        ifc.if_req = 1; ifc.if_addr = 32'h10; mem_word = 32'h00A00093;
        run_txn(0, 0, 0);
        chk("t35_if_rdata", ifc.if_rdata, 32'h00A00093);
        chk("t35_owner",    32'(ifc.owner), 32'd0);

        // simultaneous requests with streak 0: data first, then fetch
        ifc.if_req = 1; ifc.if_addr = 32'h20;
        ifc.dm_req = 1; ifc.dm_we = 0; ifc.dm_addr = 32'h200; ifc.dm_digit = 2'b10;
        mem_word = 32'hCAFE0001;
        run_txn(0, 0, 0);
        chk("t36_first_dm", 32'(ifc.owner), 32'd1);
        mem_word = 32'hCAFE0002;
        run_txn(0, 0, 0);
        chk("t36_then_if", 32'(ifc.owner), 32'd0);

        // starvation guard with both requests held
        order = 6'b011011;
        ifc.if_req = 1; ifc.dm_req = 1;
        for (int i = 0; i < 6; i++) begin
            mem_word = $urandom;
            run_txn(1, 0, 0);
            chk("t37_order", 32'(ifc.owner), 32'(order[i]));
        end
        ifc.if_req = 0; ifc.dm_req = 0;
        tick();

        // byte store must leave dm_rdata alone
        saved = m_dm_rd;
        ifc.dm_req = 1; ifc.dm_we = 1; ifc.dm_addr = 32'h100; ifc.dm_wdata = 32'hDEADBEEF;
        ifc.dm_digit = 2'b00; mem_word = 32'h12345678;
        run_txn(0, 0, 0);
        chk("t38_dm_rd_kept", ifc.dm_rdata, saved);

        // request dropped during ACCESS still completes, and nothing follows
        ifc.dm_req = 1; ifc.dm_we = 0; ifc.dm_addr = 32'h300; ifc.dm_digit = 2'b01;
        mem_word = 32'h5A5A1234;
        run_txn(0, 1, 0);
        tick();
        chk("t40_no_regrant", 32'(ifc.busy), 32'd0);

        // reset during the last ACCESS cycle
        ifc.dm_req = 1; ifc.dm_we = 0; ifc.dm_addr = 32'h400;
        tick(); tick();
        #2 Reset = 1'b0;
        #1;
        chk("t39_busy",  32'(ifc.busy), 32'd0);
        chk("t39_quiet", 32'({ifc.mem_en, ifc.mem_we, ifc.if_ack, ifc.dm_ack}), 32'd0);
        chk("t39_owner", 32'(ifc.owner), 32'd0);
        chk("t39_addr",  ifc.mem_addr, 32'd0);
        chk("t39_rdata", ifc.if_rdata | ifc.dm_rdata, 32'd0);
        ifc.dm_req = 0; ifc.if_req = 1; ifc.if_addr = 32'h40;
        tick();
        chk("t39_held_quiet", 32'({ifc.busy, ifc.if_ack, ifc.dm_ack}), 32'd0);
        model_reset();
        @(negedge CLK); Reset = 1'b1;
        mem_word = 32'h0BADF00D;
        run_txn(0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = 2'($urandom_range(0, 3));
            ifc.if_req = r[0]; ifc.dm_req = r[1];
            ifc.if_addr = $urandom; ifc.dm_addr = $urandom; ifc.dm_wdata = $urandom;
            ifc.dm_we = 1'($urandom); ifc.dm_digit = 2'($urandom_range(0, 2));
            mem_word = $urandom;
            if (r == 2'b00) begin
                tick();
                chk("rnd_idle_busy",  32'(ifc.busy), 32'd0);
                chk("rnd_idle_owner", 32'(ifc.owner), 32'(m_owner));
            end else begin
                run_txn(1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
